// File: rtl/romulus_ctrl_pkg.sv
// Shared types and constants for the Romulus-N x4 sequencing controller.
package romulus_ctrl_pkg;

    localparam int ROUNDS     = 56;
    localparam int RPC        = 4;
    localparam int WORDS      = 4;
    localparam int ENC_CYCLES = ROUNDS / RPC;

    localparam logic [3:0] DEC_MASK = 4'hF;

    // 4 bits hold 0..14: the counter steps once more as ENC exits.
    localparam int              RND_W    = 4;
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(ENC_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_NONCE,
        LOAD_STATE,
        ENC,
        REVERT,
        OUT
    } state_t;

endpackage

// File: rtl/romulus_beat_cnt.sv
// Two-bit handshake beat counter with a last-beat flag. It wraps naturally, so
// each 4-beat phase leaves it at 0 for the next phase.
module romulus_beat_cnt
    import romulus_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       beat,
    output logic [1:0] cnt,
    output logic       last
);

    // Count accepted beats; synchronous clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (beat) begin
            cnt <= cnt + 2'd1;
        end
    end

    assign last = (cnt == 2'(WORDS - 1));

endmodule

// File: rtl/romulus_ctrl_x4.sv
// Sequencing controller for the 4-rounds-per-cycle Romulus-N datapath.
// Optional build macro ROMULUS_CTRL_PERF_CNT_EN adds the blk_cnt and
// stall_cnt performance counters.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start; dom_in/dec_in latched on accept
// LOAD_KEY   | 4 sdi beats shifted into TK-X
// LOAD_NONCE | 4 pdi beats shifted into TK-Y
// LOAD_STATE | 4 pdi beats shifted into the state; erst on the last beat
// ENC        | 14 cycles of 4 SKINNY rounds each, all lanes enabled
// REVERT     | restore TK1/TK2, load advanced counter with domain byte
// OUT        | 4 pdo beats shifted out; done on the last one
module romulus_ctrl_x4
    import romulus_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  dom_in,
    input  logic        dec_in,
    output logic        busy,
    output logic        done,
    input  logic        sdi_valid,
    output logic        sdi_ready,
    input  logic        pdi_valid,
    output logic        pdi_ready,
    output logic        pdo_valid,
    input  logic        pdo_ready,
    output logic        srst,
    output logic        senc,
    output logic        sse,
    output logic        xrst,
    output logic        xenc,
    output logic        xse,
    output logic        yrst,
    output logic        yenc,
    output logic        yse,
    output logic        zrst,
    output logic        zenc,
    output logic        zse,
    output logic        erst,
    output logic        correct_cnt,
    output logic        tk1s,
    output logic [7:0]  domain,
`ifdef ROMULUS_CTRL_PERF_CNT_EN
    output logic [15:0] blk_cnt,
    output logic [15:0] stall_cnt,
`endif
    output logic [3:0]  decrypt
);

    state_t           state;
    logic [RND_W-1:0] rnd;
    logic [7:0]       dom_q;
    logic             dec_q;
    logic             sdi_hs;
    logic             pdi_hs;
    logic             pdo_hs;
    logic             beat_last;
    logic [1:0]       beat_cnt;

    assign sdi_hs = (state == LOAD_KEY) && sdi_valid;
    assign pdi_hs = ((state == LOAD_NONCE) || (state == LOAD_STATE)) && pdi_valid;
    assign pdo_hs = (state == OUT) && pdo_ready;

    romulus_beat_cnt u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .beat (sdi_hs | pdi_hs | pdo_hs),
        .cnt  (beat_cnt),
        .last (beat_last)
    );

    // Phase sequencing, round counter and per-block latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rnd   <= '0;
            dom_q <= '0;
            dec_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dom_q <= dom_in;
                        dec_q <= dec_in;
                        state <= LOAD_KEY;
                    end
                end
                LOAD_KEY:   if (sdi_hs && beat_last) state <= LOAD_NONCE;
                LOAD_NONCE: if (pdi_hs && beat_last) state <= LOAD_STATE;
                LOAD_STATE: if (pdi_hs && beat_last) state <= ENC;
                ENC: begin
                    rnd <= rnd + RND_W'(1);
                    if (rnd == RND_LAST) state <= REVERT;
                end
                REVERT: state <= OUT;
                OUT: begin
                    if (pdo_hs && beat_last) begin
                        state <= IDLE;
                        rnd   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign srst = rst;
    assign zrst = rst;
    assign xrst = 1'b0;
    assign yrst = 1'b0;

    // Datapath controls decoded from phase and the live handshakes; all held
    // low while reset is asserted so an aborted block leaves nothing enabled.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        sdi_ready   = 1'b0;
        pdi_ready   = 1'b0;
        pdo_valid   = 1'b0;
        senc        = 1'b0;
        sse         = 1'b0;
        xenc        = 1'b0;
        xse         = 1'b0;
        yenc        = 1'b0;
        yse         = 1'b0;
        zenc        = 1'b0;
        zse         = 1'b0;
        erst        = 1'b0;
        correct_cnt = 1'b0;
        tk1s        = 1'b0;
        domain      = 8'h00;
        decrypt     = 4'h0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                LOAD_KEY: begin
                    sdi_ready = 1'b1;
                    tk1s      = 1'b1;
                    xenc      = sdi_hs;
                    xse       = sdi_hs;
                end
                LOAD_NONCE: begin
                    pdi_ready = 1'b1;
                    tk1s      = 1'b1;
                    yenc      = pdi_hs;
                    yse       = pdi_hs;
                end
                LOAD_STATE: begin
                    pdi_ready = 1'b1;
                    senc      = pdi_hs;
                    sse       = pdi_hs;
                    erst      = pdi_hs && beat_last;
                end
                ENC: begin
                    senc = 1'b1;
                    xenc = 1'b1;
                    yenc = 1'b1;
                    zenc = 1'b1;
                end
                REVERT: begin
                    xenc        = 1'b1;
                    yenc        = 1'b1;
                    zenc        = 1'b1;
                    xse         = 1'b1;
                    yse         = 1'b1;
                    zse         = 1'b1;
                    correct_cnt = 1'b1;
                    domain      = dom_q;
                end
                OUT: begin
                    pdo_valid = 1'b1;
                    decrypt   = dec_q ? DEC_MASK : 4'h0;
                    senc      = pdo_hs;
                    sse       = pdo_hs;
                    done      = pdo_hs && beat_last;
                end
                default: ;
            endcase
        end
    end

`ifdef ROMULUS_CTRL_PERF_CNT_EN
    logic stall;

    assign stall = ((state == LOAD_KEY) && !sdi_valid) ||
                   (((state == LOAD_NONCE) || (state == LOAD_STATE)) && !pdi_valid) ||
                   ((state == OUT) && !pdo_ready);

    // Completed-block counter wraps; stall counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (done) blk_cnt <= blk_cnt + 16'd1;
            if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_romulus_ctrl_x4.sv
module tb_romulus_ctrl_x4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  dom_in = 8'h00;
    logic        dec_in = 1'b0;
    logic        busy, done, sdi_ready, pdi_ready, pdo_valid;
    logic        sdi_valid = 1'b0;
    logic        pdi_valid = 1'b0;
    logic        pdo_ready = 1'b0;
    logic        srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse;
    logic        erst, correct_cnt, tk1s;
    logic [7:0]  domain;
    logic [3:0]  decrypt;
`ifdef ROMULUS_CTRL_PERF_CNT_EN
    logic [15:0] blk_cnt, stall_cnt;
`endif

    romulus_ctrl_x4 dut (
        .clk(clk), .rst(rst), .start(start), .dom_in(dom_in), .dec_in(dec_in),
        .busy(busy), .done(done),
        .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
        .pdi_valid(pdi_valid), .pdi_ready(pdi_ready),
        .pdo_valid(pdo_valid), .pdo_ready(pdo_ready),
        .srst(srst), .senc(senc), .sse(sse),
        .xrst(xrst), .xenc(xenc), .xse(xse),
        .yrst(yrst), .yenc(yenc), .yse(yse),
        .zrst(zrst), .zenc(zenc), .zse(zse),
        .erst(erst), .correct_cnt(correct_cnt), .tk1s(tk1s),
        .domain(domain),
`ifdef ROMULUS_CTRL_PERF_CNT_EN
        .blk_cnt(blk_cnt), .stall_cnt(stall_cnt),
`endif
        .decrypt(decrypt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy, done, sdi_ready, pdi_ready, pdo_valid;
        logic srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse;
        logic erst, correct_cnt, tk1s;
        logic [7:0] domain;
        logic [3:0] decrypt;
    } outv_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: a block is a count of accepted beats (0..15) plus a
    // count of post-load cycles (0..13 rounds, 14 revert, 15 output).
    bit         m_active = 0;
    int         m_hs = 0;
    int         m_e = 0;
    logic [7:0] m_dom = 8'h00;
    logic       m_dec = 1'b0;
    int         m_blk = 0;
    int         m_stall = 0;

    int n_sdi, n_pdi, n_pdo, n_erst, n_enc, n_cc, n_done, n_zenc, first_pdo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic outv_t observed();
        outv_t o;
        o = {busy, done, sdi_ready, pdi_ready, pdo_valid,
             srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse,
             erst, correct_cnt, tk1s, domain, decrypt};
        return o;
    endfunction

    function automatic outv_t model_exp();
        outv_t o;
        o = '0;
        if (rst) begin
            o.srst = 1'b1;
            o.zrst = 1'b1;
        end else if (m_active) begin
            o.busy = 1'b1;
            if (m_hs < 4) begin
                o.sdi_ready = 1'b1; o.tk1s = 1'b1;
                o.xenc = sdi_valid; o.xse = sdi_valid;
            end else if (m_hs < 8) begin
                o.pdi_ready = 1'b1; o.tk1s = 1'b1;
                o.yenc = pdi_valid; o.yse = pdi_valid;
            end else if (m_hs < 12) begin
                o.pdi_ready = 1'b1;
                o.senc = pdi_valid; o.sse = pdi_valid;
                o.erst = pdi_valid && (m_hs == 11);
            end else if (m_e < 14) begin
                o.senc = 1'b1; o.xenc = 1'b1; o.yenc = 1'b1; o.zenc = 1'b1;
            end else if (m_e == 14) begin
                o.xenc = 1'b1; o.yenc = 1'b1; o.zenc = 1'b1;
                o.xse = 1'b1; o.yse = 1'b1; o.zse = 1'b1;
                o.correct_cnt = 1'b1; o.domain = m_dom;
            end else begin
                o.pdo_valid = 1'b1;
                o.decrypt = m_dec ? 4'hF : 4'h0;
                o.senc = pdo_ready; o.sse = pdo_ready;
                o.done = pdo_ready && (m_hs == 15);
            end
        end
        return o;
    endfunction

    task automatic model_advance();
        bit in_io;
        bit hs_now;
        if (rst) begin
            m_active = 0; m_blk = 0; m_stall = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_hs = 0; m_e = 0; m_dom = dom_in; m_dec = dec_in;
            end
        end else begin
            in_io  = (m_hs < 12) || (m_e == 15);
            hs_now = (m_hs < 4) ? sdi_valid : (m_hs < 12) ? pdi_valid : pdo_ready;
            if (in_io && !hs_now && m_stall < 65535) m_stall++;
            if (m_hs < 12) begin
                if (hs_now) m_hs++;
            end else if (m_e < 15) begin
                m_e++;
            end else if (pdo_ready) begin
                if (m_hs == 15) begin
                    m_active = 0;
                    m_blk = (m_blk + 1) % 65536;
                end else begin
                    m_hs++;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("outputs", observed(), model_exp());
        if (sdi_valid && sdi_ready) n_sdi++;
        if (pdi_valid && pdi_ready) n_pdi++;
        if (pdo_valid && pdo_ready) n_pdo++;
        if (erst) n_erst++;
        if (senc && xenc && yenc && zenc && !sse && !xse) n_enc++;
        if (correct_cnt) n_cc++;
        if (done) n_done++;
        if (zenc) n_zenc++;
        if (pdo_valid && first_pdo < 0) first_pdo = cyc;
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_block(input logic [7:0] dom, input logic dec, input bit stall,
                             input bit hold_start, input int abort_e, input bit chk_lat);
        int n;
        int start_cyc;
        n_sdi = 0; n_pdi = 0; n_pdo = 0; n_erst = 0; n_enc = 0;
        n_cc = 0; n_done = 0; n_zenc = 0; first_pdo = -1;
        dom_in = dom; dec_in = dec; start = 1'b1;
        sdi_valid = 1'b1; pdi_valid = 1'b1; pdo_ready = 1'b1;
        start_cyc = cyc;
        cycle();
        if (!hold_start) start = 1'b0;
        n = 0;
        while (m_active && n < 400) begin
            sdi_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            pdi_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            pdo_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold_start && m_e >= 15) start = 1'b0;
            if (abort_e >= 0 && m_hs == 12 && m_e == abort_e) rst = 1'b1;
            cycle();
            rst = 1'b0;
            n++;
        end
        start = 1'b0;
        if (abort_e >= 0) begin
            sdi_valid = 1'b0; pdi_valid = 1'b0; pdo_ready = 1'b0;
            cycle();
            chk("abort_no_done", 32'(n_done), 32'd0);
            chk("abort_enc_partial", 32'(n_enc), 32'(abort_e));
        end else begin
            chk("sdi_beats", 32'(n_sdi), 32'd4);
            chk("pdi_beats", 32'(n_pdi), 32'd8);
            chk("pdo_beats", 32'(n_pdo), 32'd4);
            chk("erst_cycles", 32'(n_erst), 32'd1);
            chk("enc_cycles", 32'(n_enc), 32'd14);
            chk("revert_cycles", 32'(n_cc), 32'd1);
            chk("zenc_cycles", 32'(n_zenc), 32'd15);
            chk("done_pulses", 32'(n_done), 32'd1);
            if (chk_lat) chk("first_pdo_latency", 32'(first_pdo - start_cyc), 32'd28);
        end
        sdi_valid = 1'b0; pdi_valid = 1'b0; pdo_ready = 1'b0;
    endtask

    initial begin
        // Reset: two cycles with reset held, then one idle cycle.
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("idle_busy", 32'(busy), 32'd0);

        // Clean block, domain 0x2D, encrypt, latency measured.
        run_block(8'h2D, 1'b0, 1'b0, 1'b0, -1, 1'b1);

        // Stalled block, decrypt.
        run_block(8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0, -1, 1'b0);

        // start held high across the block, then an immediate second block.
        run_block(8'hA5, 1'b0, 1'b0, 1'b1, -1, 1'b1);
        run_block(8'hA5, 1'b0, 1'b0, 1'b0, -1, 1'b1);

        // Reset with round counter at 7, then a full block.
        run_block(8'h3C, 1'b1, 1'b0, 1'b0, 7, 1'b0);
        run_block(8'h3C, 1'b1, 1'b0, 1'b0, -1, 1'b1);

        // Random stalled blocks with random domain/direction.
        for (int i = 0; i < 3; i++) begin
            run_block(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, -1, 1'b0);
            repeat (int'($urandom_range(0, 3))) cycle();
        end

`ifdef ROMULUS_CTRL_PERF_CNT_EN
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) run_block(8'h11, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        chk("blk_cnt_3", 32'(blk_cnt), 32'd3);
        chk("stall_cnt_0", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 2; i++) run_block(8'h22, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        chk("blk_cnt_model", 32'(blk_cnt), 32'(m_blk));
        chk("stall_cnt_model", 32'(stall_cnt), 32'(m_stall));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
